// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and constants.
// Imported by the hazard unit and its load-use detector.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  // Saturating +1 for the 32-bit performance counters.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic        en
  );
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX
// and the source registers of the instruction in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_mem_read_i,
  output logic             lu_hit_o
);

  // x0 is never a real dependency, so it never stalls.
  always_comb begin
    lu_hit_o = ex_mem_read_i
            && (ex_rd_i != '0)
            && ((ex_rd_i == id_rs1_i)
             || (ex_rd_i == id_rs2_i));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush,
// data-memory freeze with timeout, and perf counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16,
  parameter int BR_PENALTY   = 1
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_timeout,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
);

  localparam int WW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WW-1:0] WT = WW'(WAIT_TIMEOUT);
  localparam logic [1:0]    BP = 2'(BR_PENALTY);

  state_e        state_q, state_d;
  logic          pend_q, pend_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0]    pen_q, pen_d;
  logic          tmo_q, tmo_d;
  logic [31:0]   scnt_q, scnt_d;
  logic [31:0]   fcnt_q, fcnt_d;

  logic lu_hit;
  logic in_wait;
  logic frz_entry;
  logic hold;
  logic tmo_hit;
  logic freeze;
  logic redir;

  hazard_detect u_det (
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .ex_rd_i       (ex_rd),
    .ex_mem_read_i (ex_mem_read),
    .lu_hit_o      (lu_hit)
  );

  // Freeze and redirect qualifiers shared by both comb processes.
  always_comb begin
    in_wait   = (state_q == MEM_WAIT);
    frz_entry = !in_wait && mem_req && !mem_ready;
    hold      = in_wait && !mem_ready && (wait_q != WT);
    tmo_hit   = in_wait && !mem_ready && (wait_q == WT);
    freeze    = frz_entry || hold;
    redir     = ex_redirect || (in_wait && pend_q);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      wait_q  <= '0;
      pen_q   <= '0;
      tmo_q   <= 1'b0;
      scnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wait_q  <= wait_d;
      pen_q   <= pen_d;
      tmo_q   <= tmo_d;
      scnt_q  <= scnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next state: freeze first, then redirect, then flush countdown.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    wait_d  = wait_q;
    pen_d   = pen_q;
    tmo_d   = tmo_q | tmo_hit;
    scnt_d  = sat_inc(scnt_q, pc_stall);
    fcnt_d  = sat_inc(fcnt_q, if_id_flush);
    if (freeze) begin
      // A redirect seen while frozen waits for the exit cycle.
      state_d = MEM_WAIT;
      pend_d  = (in_wait && pend_q) || ex_redirect;
      wait_d  = in_wait ? wait_q + 1'b1 : '0;
      pen_d   = '0;
    end else if (redir) begin
      state_d = (BR_PENALTY > 0) ? FLUSH : RUN;
      pend_d  = 1'b0;
      wait_d  = '0;
      pen_d   = BP;
    end else begin
      pend_d = 1'b0;
      wait_d = '0;
      if (state_q == FLUSH && pen_q > 2'd1) begin
        state_d = FLUSH;
        pen_d   = pen_q - 2'd1;
      end else begin
        state_d = RUN;
        pen_d   = '0;
      end
    end
  end

  // Outputs: a stage is never stalled and flushed together.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (rst_n) begin
      priority case (1'b1)
        freeze: begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
        end
        redir: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        (state_q == FLUSH): begin
          if_id_flush = 1'b1;
        end
        lu_hit: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_timeout = tmo_q;
  assign stall_cnt   = scnt_q;
  assign flush_cnt   = fcnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random
// traffic against a behavioural model of the pipeline rules.
module tb_hazard_ctrl;

  localparam int WT = 4;
  localparam int BP = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_mem_read, ex_redirect, mem_req, mem_ready;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic        if_id_flush, id_ex_flush, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .WAIT_TIMEOUT (WT),
    .BR_PENALTY   (BP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_redirect  (ex_redirect),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .id_ex_stall  (id_ex_stall),
    .ex_mem_stall (ex_mem_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .mem_timeout  (mem_timeout),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  int ncmp = 0;
  int nerr = 0;

  // Model: waiting flag, cycles spent waiting, pending redirect,
  // remaining penalty flush cycles, sticky timeout, counters.
  bit     m_waiting;
  int     m_wcnt;
  bit     m_pend;
  int     m_left;
  bit     m_tmo;
  longint m_sc, m_fc;

  logic [5:0] last_obs;

  function automatic logic [5:0] obs_vec();
    return {pc_stall, if_id_stall, id_ex_stall,
            ex_mem_stall, if_id_flush, id_ex_flush};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_waiting = 0;
    m_wcnt    = 0;
    m_pend    = 0;
    m_left    = 0;
    m_tmo     = 0;
    m_sc      = 0;
    m_fc      = 0;
  endtask

  function automatic longint sat(input longint v);
    return (v < 64'hFFFF_FFFF) ? v + 1 : v;
  endfunction

  // One clock: drive at negedge, check, then step model on posedge.
  task automatic cyc(input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd,  input logic mr,
                     input logic br,        input logic mq,
                     input logic rdy);
    bit lu, frz, tmo_now, rdr;
    logic [5:0] e;
    id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
    ex_mem_read = mr; ex_redirect = br;
    mem_req = mq; mem_ready = rdy;
    #1;
    lu = mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
    if (m_waiting) begin
      frz     = !rdy && (m_wcnt < WT);
      tmo_now = !rdy && (m_wcnt >= WT);
    end else begin
      frz     = mq && !rdy;
      tmo_now = 0;
    end
    rdr = br || (m_waiting && m_pend);
    if (frz)             e = 6'b111100;
    else if (rdr)        e = 6'b000011;
    else if (m_left > 0) e = 6'b000010;
    else if (lu)         e = 6'b110001;
    else                 e = 6'b000000;
    last_obs = obs_vec();
    chk("ctl", last_obs, e);
    chk("stall_cnt", stall_cnt, m_sc);
    chk("flush_cnt", flush_cnt, m_fc);
    chk("mem_timeout", mem_timeout, m_tmo);
    @(posedge clk);
    if (e[5]) m_sc = sat(m_sc);
    if (e[1]) m_fc = sat(m_fc);
    if (frz) begin
      if (!m_waiting) begin
        m_waiting = 1; m_wcnt = 0; m_pend = br;
      end else begin
        m_wcnt++; m_pend = m_pend || br;
      end
      m_left = 0;
    end else begin
      if (tmo_now) m_tmo = 1;
      m_waiting = 0;
      m_pend    = 0;
      if (rdr) m_left = BP;
      else if (m_left > 0) m_left--;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_mem_read = 0; ex_redirect = 0;
    mem_req = 0; mem_ready = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ctl", obs_vec(), 6'b0);
    chk("rst_scnt", stall_cnt, 0);
    chk("rst_fcnt", flush_cnt, 0);
    chk("rst_tmo", mem_timeout, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // x0 destination never stalls
    cyc(5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("x0_nostall", last_obs, 6'b000000);

    // load-use on rs2 for a single cycle
    cyc(5'd7, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_hit", last_obs, 6'b110001);
    idle();
    chk("lu_after", last_obs, 6'b000000);
    chk("lu_scnt", stall_cnt, 1);

    // redirect pulse: two if_id flushes, one id_ex flush
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("br_cyc0", last_obs, 6'b000011);
    idle();
    chk("br_cyc1", last_obs, 6'b000010);
    idle();
    chk("br_cyc2", last_obs, 6'b000000);
    chk("br_fcnt", flush_cnt, 2);

    // three-cycle memory wait with a redirect in the middle
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mw_0", last_obs, 6'b111100);
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("mw_1", last_obs, 6'b111100);
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mw_2", last_obs, 6'b111100);
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("mw_exit", last_obs, 6'b000011);
    idle();
    chk("mw_pen", last_obs, 6'b000010);
    idle();

    // timeout: entry + WT stalled wait cycles, then drop
    for (int i = 0; i < WT + 1; i++) begin
      cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("to_stall", last_obs, 6'b111100);
    end
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("to_drop", last_obs, 6'b000000);
    idle();
    chk("to_set", mem_timeout, 1);
    idle();
    chk("to_sticky", mem_timeout, 1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 19) < 7));
    end

    // reset in the middle of a memory wait
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    id_rs1 = 5'd9; ex_rd = 5'd9; ex_mem_read = 1'b1;
    mem_req = 1'b1; mem_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mw_ctl", obs_vec(), 6'b0);
    chk("rst_mw_scnt", stall_cnt, 0);
    chk("rst_mw_fcnt", flush_cnt, 0);
    chk("rst_mw_tmo", mem_timeout, 0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_run", last_obs, 6'b110001);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: WAIT_TIMEOUT, 16, max consecutive MEM_WAIT cycles before timeout.
REQ-002 Parameter: BR_PENALTY, 1, extra cycles if_id_flush holds after the redirect cycle (0..3).
REQ-003 Port: clk  in  1  sole clock, rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Ports: id_rs1, id_rs2  in  5  source registers of the instruction in ID.
REQ-006 Ports: ex_rd  in  5, and ex_mem_read  in  1: destination and load flag of the instruction in EX.
REQ-007 Port: ex_redirect  in  1  branch/jump taken in EX; PC is being redirected.
REQ-008 Ports: mem_req  in  1, and mem_ready  in  1: data-memory access in MEM and its completion.
REQ-009 Ports: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the corresponding register.
REQ-010 Ports: if_id_flush, id_ex_flush  out  1 each  load NOP (0x00000013) and pc 0 into the register.
REQ-011 Ports: mem_timeout  out  1  sticky error flag; stall_cnt, flush_cnt  out  32  performance counters.

Function
REQ-012 FSM states SHALL be RUN, MEM_WAIT and FLUSH.
REQ-013 Load-use SHALL be detected when ex_mem_read=1, ex_rd!=0 and ex_rd equals id_rs1 or id_rs2.
REQ-014 In RUN, a load-use hit SHALL assert pc_stall, if_id_stall and id_ex_flush in the same cycle (combinational), for exactly one cycle.
REQ-015 In RUN, ex_redirect=1 SHALL assert if_id_flush and id_ex_flush that cycle, override load-use, and go to FLUSH if BR_PENALTY>0.
REQ-016 FLUSH SHALL assert if_id_flush for BR_PENALTY cycles, then return to RUN; a new ex_redirect in FLUSH restarts the count.
REQ-017 mem_req=1 with mem_ready=0 in RUN or FLUSH SHALL assert all four stall outputs that cycle and enter MEM_WAIT; this freeze has top priority.
REQ-018 MEM_WAIT SHALL hold all four stalls and no flushes until mem_ready=1, which releases the stalls that same cycle and returns to RUN, or to FLUSH if a redirect is pending.
REQ-019 A redirect that occurs during a freeze SHALL be latched as pending, not acted on until exit, and consumed on exit by asserting both flushes that cycle.
REQ-020 The wait counter SHALL count cycles in MEM_WAIT. When it reaches WAIT_TIMEOUT, the block SHALL set mem_timeout (sticky until reset), drop the stalls and return to RUN.
REQ-021 Stall and flush of the same register SHALL never be asserted together; flush wins except during a freeze.
REQ-022 stall_cnt SHALL increment on every cycle pc_stall=1.
REQ-023 flush_cnt SHALL increment on every cycle if_id_flush=1.
REQ-024 Both counters SHALL saturate at 0xFFFFFFFF.

Reset
REQ-025 rst_n=0 SHALL immediately force state RUN and clear the pending redirect, the wait counter, stall_cnt, flush_cnt and mem_timeout.
REQ-026 rst_n=0 SHALL immediately drive all stall and flush outputs to 0.
REQ-027 Reset asserted mid-MEM_WAIT or mid-FLUSH SHALL abandon that state; after release the block starts in RUN at the next rising edge.

Structure
REQ-028 Package pipe_ctrl_pkg SHALL hold the state enum, NOP_INST (0x00000013) and the register-index width (5).
REQ-029 Sub-module hazard_detect SHALL implement the combinational load-use compare from REQ-013; the FSM and counters SHALL live in hazard_ctrl.

Verification
REQ-030 Bench SHALL cover: ex_mem_read=1, ex_rd=5, id_rs2=5 -> pc_stall, if_id_stall and id_ex_flush =1 for one cycle; stall_cnt=1.
REQ-031 Bench SHALL cover: ex_rd=0 with ex_mem_read=1 and id_rs1=0 -> no stall.
REQ-032 Bench SHALL cover: ex_redirect pulse with BR_PENALTY=1 -> if_id_flush high for 2 cycles, id_ex_flush for 1; flush_cnt=2.
REQ-033 Bench SHALL cover: mem_req=1, mem_ready low 3 cycles -> all stalls high for 3 cycles, none the cycle mem_ready=1; redirect during the wait -> both flushes on exit.
REQ-034 Bench SHALL cover: mem_ready held low with WAIT_TIMEOUT=4 -> mem_timeout set after 4 cycles and stays set, stalls drop.
REQ-035 Bench SHALL cover: rst_n low in MEM_WAIT -> outputs 0 without a clock edge, counters 0, RUN after release.
